// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX stage boundary bundle: decode-side inputs, EX-side registered outputs
// and the bubble performance counter.
interface id_ex_pipe_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned CNT_W  = 16
);
  // Decode-stage side
  logic              id_valid;
  logic [DATA_W-1:0] id_pc4;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm_ext;
  logic [4:0]        id_rs_addr;
  logic [4:0]        id_rt_addr;
  logic [4:0]        id_rd_addr;
  logic [4:0]        id_shamt;
  logic [CTRL_W-1:0] id_ctrl;

  // Execute-stage side
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc4;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm_ext;
  logic [4:0]        ex_rs_addr;
  logic [4:0]        ex_rt_addr;
  logic [4:0]        ex_rd_addr;
  logic [4:0]        ex_shamt;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_pc4, id_rs_data, id_rt_data, id_imm_ext,
           id_rs_addr, id_rt_addr, id_rd_addr, id_shamt, id_ctrl,
    input  ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext,
           ex_rs_addr, ex_rt_addr, ex_rd_addr, ex_shamt, ex_ctrl, bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc4, id_rs_data, id_rt_data, id_imm_ext,
           id_rs_addr, id_rt_addr, id_rd_addr, id_shamt, id_ctrl,
    output ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext,
           ex_rs_addr, ex_rt_addr, ex_rd_addr, ex_shamt, ex_ctrl, bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage MIPS core. Holds on stall, inserts
// an all-zero bubble on flush or when ID has no valid instruction, and keeps
// a saturating count of bubbles entering EX.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  input logic stall,
  input logic flush,
  id_ex_pipe_reg_if.slave bus
);

  // An all-zero payload is a bubble: ex_valid=0 and ex_ctrl=0 together.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm_ext;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [4:0]        rd_addr;
    logic [4:0]        shamt;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;

  payload_t         pay_q, pay_d, id_pay;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bubble;

  // Next-state selection: flush beats stall, stall holds, otherwise load or bubble.
  always_comb begin
    id_pay = '{valid:   1'b1,
               pc4:     bus.id_pc4,
               rs_data: bus.id_rs_data,
               rt_data: bus.id_rt_data,
               imm_ext: bus.id_imm_ext,
               rs_addr: bus.id_rs_addr,
               rt_addr: bus.id_rt_addr,
               rd_addr: bus.id_rd_addr,
               shamt:   bus.id_shamt,
               ctrl:    bus.id_ctrl};
    pay_d  = pay_q;
    cnt_d  = cnt_q;
    bubble = flush || (!stall && !bus.id_valid);
    if (bubble) begin
      pay_d = '0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!stall) begin
      pay_d = id_pay;
    end
  end

  // State registers; reset dominates stall and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      pay_q <= '0;
      cnt_q <= '0;
    end else begin
      pay_q <= pay_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ex_valid   = pay_q.valid;
  assign bus.ex_pc4     = pay_q.pc4;
  assign bus.ex_rs_data = pay_q.rs_data;
  assign bus.ex_rt_data = pay_q.rt_data;
  assign bus.ex_imm_ext = pay_q.imm_ext;
  assign bus.ex_rs_addr = pay_q.rs_addr;
  assign bus.ex_rt_addr = pay_q.rt_addr;
  assign bus.ex_rd_addr = pay_q.rd_addr;
  assign bus.ex_shamt   = pay_q.shamt;
  assign bus.ex_ctrl    = pay_q.ctrl;
  assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: table of per-edge vectors on a default-width
// instance, plus a hand sequence on a CNT_W=2 instance for counter saturation.
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall, flush;
  logic rst2, stall2, flush2;

  id_ex_pipe_reg_if bus ();
  id_ex_pipe_reg_if #(.CNT_W(2)) bus2 ();

  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus)
  );

  id_ex_pipe_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .stall(stall2), .flush(flush2), .bus(bus2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, stall, flush, valid;
    logic [31:0] pc4, imm;
    logic [11:0] ctrl;
    logic [4:0]  rd;
    logic        e_valid;
    logic [31:0] e_pc4, e_imm;
    logic [11:0] e_ctrl;
    logic [4:0]  e_rd;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t v [15];

  // Remaining ID fields are derived from pc4/rd so every field is distinct.
  task automatic drive(input vec_t t);
    rst             = t.rst;
    stall           = t.stall;
    flush           = t.flush;
    bus.id_valid    = t.valid;
    bus.id_pc4      = t.pc4;
    bus.id_rs_data  = t.pc4 + 32'd1;
    bus.id_rt_data  = t.pc4 + 32'd2;
    bus.id_imm_ext  = t.imm;
    bus.id_ctrl     = t.ctrl;
    bus.id_rd_addr  = t.rd;
    bus.id_rs_addr  = t.rd ^ 5'h1F;
    bus.id_rt_addr  = t.rd + 5'd1;
    bus.id_shamt    = t.rd ^ 5'h0A;
  endtask

  task automatic check_vec(input int i, input vec_t t);
    logic [31:0] rs_e, rt_e;
    logic [4:0]  rsa_e, rta_e, sh_e;
    rs_e  = t.e_valid ? t.e_pc4 + 32'd1 : 32'd0;
    rt_e  = t.e_valid ? t.e_pc4 + 32'd2 : 32'd0;
    rsa_e = t.e_valid ? t.e_rd ^ 5'h1F : 5'd0;
    rta_e = t.e_valid ? t.e_rd + 5'd1 : 5'd0;
    sh_e  = t.e_valid ? t.e_rd ^ 5'h0A : 5'd0;
    chk($sformatf("v%0d ex_valid", i),   {31'd0, bus.ex_valid}, {31'd0, t.e_valid});
    chk($sformatf("v%0d ex_pc4", i),     bus.ex_pc4, t.e_pc4);
    chk($sformatf("v%0d ex_rs_data", i), bus.ex_rs_data, rs_e);
    chk($sformatf("v%0d ex_rt_data", i), bus.ex_rt_data, rt_e);
    chk($sformatf("v%0d ex_imm_ext", i), bus.ex_imm_ext, t.e_imm);
    chk($sformatf("v%0d ex_rs_addr", i), {27'd0, bus.ex_rs_addr}, {27'd0, rsa_e});
    chk($sformatf("v%0d ex_rt_addr", i), {27'd0, bus.ex_rt_addr}, {27'd0, rta_e});
    chk($sformatf("v%0d ex_rd_addr", i), {27'd0, bus.ex_rd_addr}, {27'd0, t.e_rd});
    chk($sformatf("v%0d ex_shamt", i),   {27'd0, bus.ex_shamt}, {27'd0, sh_e});
    chk($sformatf("v%0d ex_ctrl", i),    {20'd0, bus.ex_ctrl}, {20'd0, t.e_ctrl});
    chk($sformatf("v%0d bubble_cnt", i), {16'd0, bus.bubble_cnt}, {16'd0, t.e_cnt});
  endtask

  task automatic drive2(input logic r, input logic s, input logic f, input logic vld);
    rst2          = r;
    stall2        = s;
    flush2        = f;
    bus2.id_valid = vld;
  endtask

  task automatic check2(input string name, input logic [1:0] exp_cnt);
    chk({name, " cnt"},   {30'd0, bus2.bubble_cnt}, {30'd0, exp_cnt});
    chk({name, " valid"}, {31'd0, bus2.ex_valid}, 32'd0);
    chk({name, " ctrl"},  {20'd0, bus2.ex_ctrl}, 32'd0);
  endtask

  initial begin
    //          rst stall flush valid pc4           imm           ctrl    rd    | e_valid e_pc4       e_imm         e_ctrl  e_rd  e_cnt
    v[0]  = '{1'b1,1'b0,1'b0,1'b1, 32'hDEADBEEF, 32'h12345678, 12'hFFF, 5'd7,  1'b0, 32'h0,        32'h0,        12'h000, 5'd0,  16'd0};
    v[1]  = '{1'b1,1'b1,1'b1,1'b1, 32'hCAFEF00D, 32'h87654321, 12'h5A5, 5'd3,  1'b0, 32'h0,        32'h0,        12'h000, 5'd0,  16'd0};
    v[2]  = '{1'b0,1'b0,1'b0,1'b1, 32'h00400004, 32'hFFFF8000, 12'h0A5, 5'd5,  1'b1, 32'h00400004, 32'hFFFF8000, 12'h0A5, 5'd5,  16'd0};
    v[3]  = '{1'b0,1'b1,1'b0,1'b1, 32'h11111110, 32'h00001234, 12'h0FF, 5'd9,  1'b1, 32'h00400004, 32'hFFFF8000, 12'h0A5, 5'd5,  16'd0};
    v[4]  = '{1'b0,1'b1,1'b0,1'b1, 32'h22222220, 32'h00005678, 12'h0F0, 5'd10, 1'b1, 32'h00400004, 32'hFFFF8000, 12'h0A5, 5'd5,  16'd0};
    v[5]  = '{1'b0,1'b1,1'b0,1'b0, 32'h33333330, 32'h00009ABC, 12'hFFF, 5'd11, 1'b1, 32'h00400004, 32'hFFFF8000, 12'h0A5, 5'd5,  16'd0};
    v[6]  = '{1'b0,1'b1,1'b1,1'b1, 32'h44444440, 32'h0000DEF0, 12'h123, 5'd12, 1'b0, 32'h0,        32'h0,        12'h000, 5'd0,  16'd1};
    v[7]  = '{1'b0,1'b0,1'b0,1'b0, 32'h55555550, 32'h0000AAAA, 12'hFFF, 5'd13, 1'b0, 32'h0,        32'h0,        12'h000, 5'd0,  16'd2};
    v[8]  = '{1'b0,1'b0,1'b0,1'b1, 32'h00400010, 32'h00007FFF, 12'h800, 5'd31, 1'b1, 32'h00400010, 32'h00007FFF, 12'h800, 5'd31, 16'd2};
    v[9]  = '{1'b0,1'b1,1'b0,1'b0, 32'h66666660, 32'h0000BBBB, 12'h777, 5'd14, 1'b1, 32'h00400010, 32'h00007FFF, 12'h800, 5'd31, 16'd2};
    v[10] = '{1'b1,1'b1,1'b0,1'b1, 32'h77777770, 32'h0000CCCC, 12'h321, 5'd15, 1'b0, 32'h0,        32'h0,        12'h000, 5'd0,  16'd0};
    v[11] = '{1'b1,1'b0,1'b1,1'b1, 32'h88888880, 32'h0000DDDD, 12'h456, 5'd16, 1'b0, 32'h0,        32'h0,        12'h000, 5'd0,  16'd0};
    v[12] = '{1'b0,1'b0,1'b0,1'b1, 32'h00000000, 32'h80000000, 12'h001, 5'd0,  1'b1, 32'h00000000, 32'h80000000, 12'h001, 5'd0,  16'd0};
    v[13] = '{1'b0,1'b0,1'b1,1'b1, 32'h99999990, 32'h0000EEEE, 12'h789, 5'd17, 1'b0, 32'h0,        32'h0,        12'h000, 5'd0,  16'd1};
    v[14] = '{1'b0,1'b1,1'b0,1'b1, 32'hAAAAAAA0, 32'h0000FFFF, 12'hABC, 5'd18, 1'b0, 32'h0,        32'h0,        12'h000, 5'd0,  16'd1};

    // Second instance idles in reset until its own sequence.
    drive2(1'b1, 1'b0, 1'b0, 1'b1);
    bus2.id_pc4     = 32'h00400020;
    bus2.id_rs_data = 32'h1;
    bus2.id_rt_data = 32'h2;
    bus2.id_imm_ext = 32'h3;
    bus2.id_rs_addr = 5'd1;
    bus2.id_rt_addr = 5'd2;
    bus2.id_rd_addr = 5'd3;
    bus2.id_shamt   = 5'd4;
    bus2.id_ctrl    = 12'hFFF;

    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk);
      #1;
      check_vec(i, v[i]);
    end

    // Saturating counter, CNT_W=2: 1,2,3,3,3, bubble from invalid ID keeps 3, rst clears.
    drive2(1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    check2("sat rst", 2'd0);
    for (int unsigned k = 0; k < 5; k++) begin
      logic [1:0] exp_c;
      exp_c = (k < 3) ? 2'(k + 1) : 2'd3;
      drive2(1'b0, k[0], 1'b1, 1'b1);
      @(posedge clk); #1;
      check2($sformatf("sat flush%0d", k), exp_c);
    end
    drive2(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check2("sat bubble", 2'd3);
    drive2(1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    check2("sat rst2", 2'd0);
    // First edge after reset loads normally.
    drive2(1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("post-rst valid", {31'd0, bus2.ex_valid}, 32'd1);
    chk("post-rst ctrl",  {20'd0, bus2.ex_ctrl}, 32'h00000FFF);
    chk("post-rst pc4",   bus2.ex_pc4, 32'h00400020);
    chk("post-rst cnt",   {30'd0, bus2.bubble_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
